// File: rtl/rot_arbiter_if.sv
// Request/result bundle for rot_arbiter: two rotate requesters and one result port.
// master = requesters and consumer side, slave = arbiter side.
interface rot_arbiter_if #(parameter int N = 3);
  localparam int W = 1 << N;

  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  logic [N-1:0] a_amt;
  logic         a_dir;

  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b_data;
  logic [N-1:0] b_amt;
  logic         b_dir;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_src;

  modport master (
    output a_valid, a_data, a_amt, a_dir,
    input  a_ready,
    output b_valid, b_data, b_amt, b_dir,
    input  b_ready,
    input  out_valid, out_data, out_src,
    output out_ready
  );

  modport slave (
    input  a_valid, a_data, a_amt, a_dir,
    output a_ready,
    input  b_valid, b_data, b_amt, b_dir,
    output b_ready,
    output out_valid, out_data, out_src,
    input  out_ready
  );
endinterface

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one right-rotator between two requesters.
// ROT_ARBITER_LEFT_EN enables left rotation via amount negation.
module rot_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  rot_arbiter_if.slave bus
);
  localparam int W = 1 << N;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_last_b;
  logic [W-1:0] r_data;
  logic         r_src;

  logic         w_free;
  logic         w_gnt_a;
  logic         w_gnt_b;
  logic         w_a_rdy;
  logic         w_b_rdy;
  logic         w_acc;
  logic [W-1:0] w_din;
  logic [N-1:0] w_amt;
  logic [N-1:0] w_amt_eff;
  logic [W-1:0] w_stg [N+1];

  // Grant is computed from valids and pointer only, never from payload.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    unique case (1'b1)
      (bus.a_valid & bus.b_valid): begin
        w_gnt_a = r_last_b;
        w_gnt_b = ~r_last_b;
      end
      (bus.a_valid & ~bus.b_valid): w_gnt_a = 1'b1;
      (~bus.a_valid & bus.b_valid): w_gnt_b = 1'b1;
      default: ;
    endcase
  end

  assign w_free  = rst_n & ((r_state == EMPTY) | bus.out_ready);
  assign w_a_rdy = w_free & w_gnt_a;
  assign w_b_rdy = w_free & w_gnt_b;
  assign w_acc   = w_a_rdy | w_b_rdy;

  assign bus.a_ready = w_a_rdy;
  assign bus.b_ready = w_b_rdy;

  assign w_din = w_gnt_b ? bus.b_data : bus.a_data;
  assign w_amt = w_gnt_b ? bus.b_amt  : bus.a_amt;

`ifdef ROT_ARBITER_LEFT_EN
  logic w_dir;
  assign w_dir     = w_gnt_b ? bus.b_dir : bus.a_dir;
  // Left by k equals right by (W-k) mod W, i.e. N-bit two's complement.
  assign w_amt_eff = w_dir ? (-w_amt) : w_amt;
`else
  logic w_unused_dir;
  assign w_unused_dir = ^{bus.a_dir, bus.b_dir};
  assign w_amt_eff    = w_amt;
`endif

  assign w_stg[0] = w_din;

  for (genvar i = 0; i < N; i++) begin : g_stage
    localparam int S = 1 << i;
    assign w_stg[i+1] = w_amt_eff[i]
                      ? {w_stg[i][S-1:0], w_stg[i][W-1:S]}
                      : w_stg[i];
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: begin
        if (w_acc) w_state_nxt = FULL;
      end
      FULL: begin
        if (w_acc)              w_state_nxt = FULL;
        else if (bus.out_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_data   <= '0;
      r_src    <= 1'b0;
      r_last_b <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_data   <= w_stg[N];
        r_src    <= w_gnt_b;
        r_last_b <= w_gnt_b;
      end
    end
  end

  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;
endmodule

// File: tb/tb_rot_arbiter.sv
// Directed testbench for rot_arbiter (N=3, W=8).
// Inputs driven at negedge; registered outputs sampled at the following negedge.
module tb_rot_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  rot_arbiter_if #(.N(3)) bus ();

  rot_arbiter #(.N(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_a(input logic v, input logic [7:0] d,
                       input logic [2:0] k, input logic dir);
    bus.a_valid = v;
    bus.a_data  = d;
    bus.a_amt   = k;
    bus.a_dir   = dir;
  endtask

  task automatic set_b(input logic v, input logic [7:0] d,
                       input logic [2:0] k, input logic dir);
    bus.b_valid = v;
    bus.b_data  = d;
    bus.b_amt   = k;
    bus.b_dir   = dir;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_a(1'b0, 8'h00, 3'd0, 1'b0);
    set_b(1'b0, 8'h00, 3'd0, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_a(1'b1, 8'hFF, 3'd1, 1'b0);
    set_b(1'b1, 8'hEE, 3'd1, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data got %h want 00", bus.out_data);
    end
    n_cmp++;
    if (bus.out_src !== 1'b0) begin
      n_err++;
      $display("FAIL reset_src got %b want 0", bus.out_src);
    end
    n_cmp++;
    if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ready got %b want 00",
               {bus.a_ready, bus.b_ready});
    end
  endtask

  task automatic test_basic();
    do_reset();
    set_a(1'b1, 8'h81, 3'd1, 1'b0);
    #1;
    n_cmp++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_ready got %b want 10",
               {bus.a_ready, bus.b_ready});
    end
    @(negedge clk);
    set_a(1'b0, 8'h00, 3'd0, 1'b0);
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'hC0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_out got v%b d%h s%b want v1 dc0 s0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.out_data} !== {1'b0, 8'hC0}) begin
      n_err++;
      $display("FAIL drain_empty got v%b d%h want v0 dc0",
               bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_a(1'b1, 8'h01, 3'd3, 1'b0);
    set_b(1'b1, 8'h80, 3'd4, 1'b0);
    #1;
    n_cmp++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL rr_first got %b want 10",
               {bus.a_ready, bus.b_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'h20, 1'b0}) begin
      n_err++;
      $display("FAIL rr_out_a got v%b d%h s%b want v1 d20 s0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    n_cmp++;
    if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL rr_second got %b want 01",
               {bus.a_ready, bus.b_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'h08, 1'b1}) begin
      n_err++;
      $display("FAIL rr_out_b got v%b d%h s%b want v1 d08 s1",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    n_cmp++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL rr_third got %b want 10",
               {bus.a_ready, bus.b_ready});
    end
    set_a(1'b0, 8'h00, 3'd0, 1'b0);
    set_b(1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_stall();
    do_reset();
    set_a(1'b1, 8'h55, 3'd0, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_a(1'b1, 8'hAA, 3'd1, 1'b0);
    set_b(1'b1, 8'hF0, 3'd2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
        n_err++;
        $display("FAIL stall_ready[%0d] got %b want 00", c,
                 {bus.a_ready, bus.b_ready});
      end
      n_cmp++;
      if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'h55, 1'b0}) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got v%b d%h s%b want v1 d55 s0",
                 c, bus.out_valid, bus.out_data, bus.out_src);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL stall_release got %b want 01",
               {bus.a_ready, bus.b_ready});
    end
    @(negedge clk);
    set_a(1'b0, 8'h00, 3'd0, 1'b0);
    set_b(1'b0, 8'h00, 3'd0, 1'b0);
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'h3C, 1'b1}) begin
      n_err++;
      $display("FAIL stall_next got v%b d%h s%b want v1 d3c s1",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    @(negedge clk);
  endtask

  task automatic test_left();
    logic [7:0] exp [3];
    logic [7:0] din [3];
    logic [2:0] amt [3];
`ifdef ROT_ARBITER_LEFT_EN
    exp = '{8'h03, 8'h81, 8'h08};
`else
    exp = '{8'hC0, 8'h81, 8'h20};
`endif
    din = '{8'h81, 8'h81, 8'h01};
    amt = '{3'd1, 3'd0, 3'd3};
    do_reset();
    for (int v = 0; v < 3; v++) begin
      set_a(1'b1, din[v], amt[v], 1'b1);
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, exp[v]}) begin
        n_err++;
        $display("FAIL left_a[%0d] got v%b d%h want v1 d%h",
                 v, bus.out_valid, bus.out_data, exp[v]);
      end
    end
    set_a(1'b0, 8'h00, 3'd0, 1'b0);
    set_b(1'b1, 8'h12, 3'd2, 1'b1);
    @(negedge clk);
    set_b(1'b0, 8'h00, 3'd0, 1'b0);
`ifdef ROT_ARBITER_LEFT_EN
    exp[0] = 8'h48;
`else
    exp[0] = 8'h84;
`endif
    n_cmp++;
    if ({bus.out_data, bus.out_src} !== {exp[0], 1'b1}) begin
      n_err++;
      $display("FAIL left_b got d%h s%b want d%h s1",
               bus.out_data, bus.out_src, exp[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    set_a(1'b1, 8'h81, 3'd1, 1'b0);
    @(negedge clk);
    set_a(1'b1, 8'h11, 3'd0, 1'b0);
    set_b(1'b1, 8'h22, 3'd0, 1'b0);
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL arst_clear got v%b d%h s%b want v0 d00 s0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL arst_ready got %b want 00",
               {bus.a_ready, bus.b_ready});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL arst_noacc got %b want 0", bus.out_valid);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL arst_tie got %b want 10",
               {bus.a_ready, bus.b_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'h11, 1'b0}) begin
      n_err++;
      $display("FAIL arst_first got v%b d%h s%b want v1 d11 s0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    set_a(1'b0, 8'h00, 3'd0, 1'b0);
    set_b(1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    set_a(1'b0, 8'h00, 3'd0, 1'b0);
    set_b(1'b0, 8'h00, 3'd0, 1'b0);
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_left();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rot_arbiter.md
ROT_ARBITER -- requirements
Module: rot_arbiter

Interface
REQ-001 Parameter N, default 3, meaning log2 of data width; data width W = 2**N, amount width N.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a_valid  input  1  requester A has a rotate request.
REQ-005 a_ready  output  1  A request accepted this cycle when a_valid & a_ready.
REQ-006 a_data  input  W  A operand.
REQ-007 a_amt  input  N  A rotate amount.
REQ-008 a_dir  input  1  A direction: 0 = right, 1 = left.
REQ-009 b_valid, b_ready, b_data, b_amt, b_dir  same directions/widths/meanings as A, for requester B.
REQ-010 out_valid  output  1  result register holds a valid result.
REQ-011 out_ready  input  1  consumer accepts result when out_valid & out_ready.
REQ-012 out_data  output  W  rotated result.
REQ-013 out_src  output  1  source of result: 0 = A, 1 = B.

Function
REQ-014 Block SHALL share one combinational right-rotator (stage i rotates right by 2**i when amt bit i set) between A and B.
REQ-015 Output FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 Slot free SHALL be defined as EMPTY, or FULL with out_ready=1 in the same cycle.
REQ-017 Arbiter SHALL grant at most one requester per cycle, only when slot free.
REQ-018 If one requester valid, it SHALL be granted; if both valid, the one not served last SHALL be granted (round-robin).
REQ-019 a_ready/b_ready SHALL be combinational: ready = slot free & granted; never both high.
REQ-020 Ready SHALL not depend on the requester's own data, amt or dir.
REQ-021 On acceptance, out_data/out_src SHALL load on the next rising edge and out_valid SHALL be 1 (latency 1 cycle).
REQ-022 FULL with out_ready=1 and a request accepted SHALL remain FULL with new result (back-to-back, one result per cycle).
REQ-023 FULL with out_ready=1 and no acceptance SHALL go EMPTY; out_data holds last value.
REQ-024 FULL with out_ready=0 SHALL hold out_data, out_src, out_valid stable; both readys 0.
REQ-025 Left rotate by k SHALL be performed as right rotate by (W - k) mod W; k = 0 passes data unchanged.
REQ-026 Last-served pointer SHALL update only on an accepted request.

Reset
REQ-027 rst_n low SHALL immediately force out_valid=0, out_data=0, out_src=0, FSM=EMPTY, last-served=B (A wins first tie).
REQ-028 A result held in FULL at reset assertion SHALL be discarded; no request is accepted while rst_n low.
REQ-029 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro ROT_ARBITER_LEFT_EN SHALL control left-rotate support.
REQ-031 Defined: a_dir/b_dir honored per REQ-025.
REQ-032 Undefined: a_dir/b_dir ignored, all requests rotate right; amount-negation logic absent.

Verification (N=3)
REQ-033 A: data 8'h81, amt 1, dir 0, out_ready 1 -> next cycle out_valid 1, out_data 8'hC0, out_src 0.
REQ-034 After reset, A and B valid same cycle -> a_ready 1, b_ready 0; next cycle b_ready 1; results A then B on consecutive cycles.
REQ-035 FULL, out_ready 0 for 3 cycles, both valid -> out_data stable, a_ready=b_ready=0 all 3 cycles; out_ready 1 -> next grant same cycle.
REQ-036 A: data 8'h81, amt 1, dir 1 -> 8'h03 with ROT_ARBITER_LEFT_EN, 8'hC0 without; amt 0 dir 1 -> 8'h81.
REQ-037 FULL, rst_n pulled low mid-cycle -> out_valid, out_data, out_src 0 before next clock edge; after release, tie grants A.
